// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and request decode helper for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] ACC_READ  = 2'b01;
  localparam logic [1:0] ACC_WRITE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_t;

  // Only read and write encodings start an access; 00 and 11 are bubbles.
  function automatic logic is_access(input logic [1:0] acc);
    return (acc == ACC_READ) || (acc == ACC_WRITE);
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Combinational lane logic: byte enables, store replication, load lane select/extension, misalignment.
// Alignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  access_sz,
  input  logic        s_us,
  input  logic [1:0]  adr_lo,
  input  logic [31:0] sd_32,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction from the addressed word; half lane ignores adr_lo[0].
  always_comb begin
    byte_s = rd_word[{adr_lo, 3'b000} +: 8];
    half_s = rd_word[{adr_lo[1], 4'b0000} +: 16];
  end

  // Misalignment detection; without the check every access is treated as aligned down.
  always_comb begin
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    case (access_sz)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = adr_lo[0];
      SZ_WORD: misalign = (adr_lo != 2'b00);
      default: misalign = 1'b1;
    endcase
`else
    misalign = 1'b0;
`endif
  end

  // Enables, replicated store data and extended load data; reserved size behaves as word.
  always_comb begin
    byte_en = 4'b0000;
    wr_data = 32'h0000_0000;
    ld_data = 32'h0000_0000;
    if (misalign) begin
      byte_en = 4'b0000;
      wr_data = sd_32;
      ld_data = 32'h0000_0000;
    end else begin
      case (access_sz)
        SZ_BYTE: begin
          byte_en = 4'b0001 << adr_lo;
          wr_data = {4{sd_32[7:0]}};
          ld_data = s_us ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
        end
        SZ_HALF: begin
          byte_en = 4'b0011 << {adr_lo[1], 1'b0};
          wr_data = {2{sd_32[15:0]}};
          ld_data = s_us ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
        end
        default: begin
          byte_en = 4'b1111;
          wr_data = sd_32;
          ld_data = rd_word;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: IDLE/WAIT/RESP FSM, latency counter, request latches, word array.
// Optional alignment checking via DMEM_MISALIGN_CHECK_EN (handled in dmem_lane_ctrl).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  acc_type,
  input  logic [1:0]  access_sz,
  input  logic        s_us,
  input  logic [31:0] dm_adr,
  input  logic [31:0] sd_32,
  output logic        rsp_valid,
  output logic [31:0] ld_32,
  output logic        rsp_err,
  output logic        stall
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  dmem_state_t       state_r, next_state_s;
  logic [3:0]        cnt_r, cnt_next_s;
  logic [ADDR_W-1:0] adr_r;
  logic [1:0]        sz_r, acc_r;
  logic              sus_r;
  logic [31:0]       sd_r;

  logic [ADDR_W-1:0] cur_adr_s;
  logic [1:0]        cur_sz_s, cur_acc_s;
  logic              cur_sus_s;
  logic [31:0]       cur_sd_s;

  logic              accept_s;
  logic [31:0]       word_num_s;
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       rd_word_s;
  logic [3:0]        byte_en_s;
  logic [31:0]       wr_data_s, ld_data_s;
  logic              misalign_s;
  logic              unused_adr_s;

  logic [31:0]       mem_r [DEPTH_WORDS];

  assign unused_adr_s = ^dm_adr[31:ADDR_W];

  assign req_ready = ~reset & (state_r == ST_IDLE);
  assign accept_s  = req_valid & req_ready & is_access(acc_type);
  assign stall     = ~reset & (((state_r == ST_IDLE) & req_valid & is_access(acc_type))
                               | (state_r == ST_WAIT));

  // Live request in IDLE (so LATENCY=1 can read on the accept edge), latched request otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_adr_s = dm_adr[ADDR_W-1:0];
      cur_sz_s  = access_sz;
      cur_acc_s = acc_type;
      cur_sus_s = s_us;
      cur_sd_s  = sd_32;
    end else begin
      cur_adr_s = adr_r;
      cur_sz_s  = sz_r;
      cur_acc_s = acc_r;
      cur_sus_s = sus_r;
      cur_sd_s  = sd_r;
    end
  end

  // Word index wraps modulo the array size.
  always_comb begin
    word_num_s = 32'(cur_adr_s[ADDR_W-1:2]);
    idx_s      = IDX_W'(word_num_s % 32'(DEPTH_WORDS));
    rd_word_s  = mem_r[idx_s];
  end

  dmem_lane_ctrl u_lane (
    .access_sz (cur_sz_s),
    .s_us      (cur_sus_s),
    .adr_lo    (cur_adr_s[1:0]),
    .sd_32     (cur_sd_s),
    .rd_word   (rd_word_s),
    .byte_en   (byte_en_s),
    .wr_data   (wr_data_s),
    .ld_data   (ld_data_s),
    .misalign  (misalign_s)
  );

  // Next-state and counter logic.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_next_s   = LAT_LOAD;
          next_state_s = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // FSM state, counter, request latches and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      adr_r     <= '0;
      sz_r      <= 2'b00;
      acc_r     <= 2'b00;
      sus_r     <= 1'b0;
      sd_r      <= 32'h0000_0000;
      rsp_valid <= 1'b0;
      ld_32     <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        adr_r <= dm_adr[ADDR_W-1:0];
        sz_r  <= access_sz;
        acc_r <= acc_type;
        sus_r <= s_us;
        sd_r  <= sd_32;
      end
      // The array is sampled only on entry to RESP; writes return zero.
      if (next_state_s == ST_RESP) begin
        rsp_valid <= 1'b1;
        ld_32     <= (cur_acc_s == ACC_READ) ? ld_data_s : 32'h0000_0000;
        rsp_err   <= misalign_s;
      end else begin
        rsp_valid <= 1'b0;
        ld_32     <= 32'h0000_0000;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Write commit on the edge ending RESP; reset drops it.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_RESP) && (acc_r == ACC_WRITE)) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] ld;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic [1:0]  acc_type  [2];
  logic [1:0]  access_sz [2];
  logic        s_us      [2];
  logic [31:0] dm_adr    [2];
  logic [31:0] sd_32     [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] ld_32     [2];
  logic        rsp_err   [2];
  logic        stall     [2];

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  dmem_responder #(.DEPTH_WORDS(256), .ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .acc_type(acc_type[0]), .access_sz(access_sz[0]), .s_us(s_us[0]), .dm_adr(dm_adr[0]),
    .sd_32(sd_32[0]), .rsp_valid(rsp_valid[0]), .ld_32(ld_32[0]), .rsp_err(rsp_err[0]),
    .stall(stall[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .acc_type(acc_type[1]), .access_sz(access_sz[1]), .s_us(s_us[1]), .dm_adr(dm_adr[1]),
    .sd_32(sd_32[1]), .rsp_valid(rsp_valid[1]), .ld_32(ld_32[1]), .rsp_err(rsp_err[1]),
    .stall(stall[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int d);
    req_valid[d] = 1'b0;
    acc_type[d]  = 2'b00;
    access_sz[d] = 2'b00;
    s_us[d]      = 1'b0;
    dm_adr[d]    = 32'h0000_0000;
    sd_32[d]     = 32'h0000_0000;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic access(input int d, input logic [1:0] acc, input logic [1:0] sz,
                        input logic sus, input logic [31:0] adr, input logic [31:0] sd,
                        input logic [31:0] exp_ld, input logic exp_err);
    int   lat;
    int   cyc;
    int   stl;
    exp_t e;
    lat    = (d == 0) ? 2 : 1;
    e.ld   = exp_ld;
    e.err  = exp_err;
    sb_q.push_back(e);
    req_valid[d] = 1'b1;
    acc_type[d]  = acc;
    access_sz[d] = sz;
    s_us[d]      = sus;
    dm_adr[d]    = adr;
    sd_32[d]     = sd;
    #1;
    chk("ready_idle", 32'(req_ready[d]), 32'd1);
    chk("stall_req", 32'(stall[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    acc_type[d]  = 2'b00;
    access_sz[d] = 2'($urandom_range(0, 3));
    s_us[d]      = 1'($urandom_range(0, 1));
    dm_adr[d]    = $urandom;
    sd_32[d]     = $urandom;
    cyc = 1;
    stl = 1;
    while ((rsp_valid[d] !== 1'b1) && (cyc < 20)) begin
      if (stall[d] === 1'b1) stl++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("stall_cycles", 32'(stl), 32'(lat));
    e = sb_q.pop_front();
    if (rsp_valid[d] === 1'b1) begin
      chk("stall_resp", 32'(stall[d]), 32'd0);
      chk("ready_resp", 32'(req_ready[d]), 32'd0);
      chk("ld_32", ld_32[d], e.ld);
      chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
    end
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    idle_inputs(0);
    idle_inputs(1);
    reset = 1'b1;
    req_valid[0] = 1'b1;
    acc_type[0]  = 2'b01;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_ld_32", ld_32[0], 32'h0);
    chk("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    idle_inputs(0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);

    // Word write then read, plus address upper bits ignored
    access(0, 2'b10, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access(0, 2'b01, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    access(0, 2'b01, 2'b10, 1'b0, 32'hF000_0410, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte loads
    access(0, 2'b10, 2'b10, 1'b0, 32'h0000_0020, 32'h80FF_7F01, 32'h0, 1'b0);
    access(0, 2'b01, 2'b00, 1'b0, 32'h0000_0021, 32'h0, 32'h0000_007F, 1'b0);
    access(0, 2'b01, 2'b00, 1'b0, 32'h0000_0023, 32'h0, 32'hFFFF_FF80, 1'b0);
    access(0, 2'b01, 2'b00, 1'b1, 32'h0000_0022, 32'h0, 32'h0000_00FF, 1'b0);
    access(0, 2'b01, 2'b00, 1'b1, 32'h0000_0020, 32'h0, 32'h0000_0001, 1'b0);

    // Half store then reads
    access(0, 2'b10, 2'b10, 1'b0, 32'h0000_0030, 32'h1122_3344, 32'h0, 1'b0);
    access(0, 2'b10, 2'b01, 1'b0, 32'h0000_0032, 32'h5A5A_ABCD, 32'h0, 1'b0);
    access(0, 2'b01, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 32'hABCD_3344, 1'b0);
    access(0, 2'b01, 2'b01, 1'b0, 32'h0000_0032, 32'h0, 32'hFFFF_ABCD, 1'b0);
    access(0, 2'b01, 2'b01, 1'b1, 32'h0000_0030, 32'h0, 32'h0000_3344, 1'b0);
    access(0, 2'b10, 2'b00, 1'b0, 32'h0000_0031, 32'h0000_00EE, 32'h0, 1'b0);
    access(0, 2'b01, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 32'hABCD_EE44, 1'b0);

    // Reset during WAIT of a write
    access(0, 2'b10, 2'b10, 1'b0, 32'h0000_0040, 32'h0000_0055, 32'h0, 1'b0);
    req_valid[0] = 1'b1;
    acc_type[0]  = 2'b10;
    access_sz[0] = 2'b10;
    dm_adr[0]    = 32'h0000_0040;
    sd_32[0]     = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    idle_inputs(0);
    chk("wait_stall", 32'(stall[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
    chk("midrst_stall", 32'(stall[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("after_rst_req_ready", 32'(req_ready[0]), 32'd1);
    access(0, 2'b01, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0055, 1'b0);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_CHECK_EN
    access(0, 2'b01, 2'b10, 1'b0, 32'h0000_0041, 32'h0, 32'h0, 1'b1);
    access(0, 2'b01, 2'b01, 1'b0, 32'h0000_0033, 32'h0, 32'h0, 1'b1);
    access(0, 2'b10, 2'b10, 1'b0, 32'h0000_0042, 32'h1234_5678, 32'h0, 1'b1);
    access(0, 2'b01, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b1);
    access(0, 2'b01, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0055, 1'b0);
`else
    access(0, 2'b01, 2'b10, 1'b0, 32'h0000_0041, 32'h0, 32'h0000_0055, 1'b0);
    access(0, 2'b01, 2'b01, 1'b0, 32'h0000_0033, 32'h0, 32'hFFFF_ABCD, 1'b0);
    access(0, 2'b10, 2'b10, 1'b0, 32'h0000_0042, 32'h1234_5678, 32'h0, 1'b0);
    access(0, 2'b01, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0);
`endif

    // No-access requests are ignored
    for (int k = 0; k < 4; k++) begin
      req_valid[0] = 1'b1;
      acc_type[0]  = (k < 2) ? 2'b00 : 2'b11;
      access_sz[0] = 2'b10;
      dm_adr[0]    = 32'h0000_0010;
      #1;
      chk("noacc_stall", 32'(stall[0]), 32'd0);
      chk("noacc_ready", 32'(req_ready[0]), 32'd1);
      @(negedge clk);
      chk("noacc_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    idle_inputs(0);
    @(negedge clk);
    chk("noacc_idle_ready", 32'(req_ready[0]), 32'd1);

    // LATENCY=1 instance
    access(1, 2'b10, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 1'b0);
    access(1, 2'b01, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b0);
    access(1, 2'b01, 2'b01, 1'b0, 32'h0000_000A, 32'h0, 32'hFFFF_CAFE, 1'b0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder at the far end of the MEM-stage access interface. Accepts one load/store request from the MEM stage, waits a fixed configurable latency, performs the byte/half/word access on a little-endian word array, and returns load data with a one-cycle response strobe. While an access is in flight it drives a stall to the pipeline, replacing the single-cycle data memory.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words in the array.
- `ADDR_W`, default 10: byte-address width used; upper `dm_adr` bits are ignored.
- `LATENCY`, default 2: cycles from request acceptance to `rsp_valid`. Legal range is 1–15.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  MEM stage presents a request.
- `req_ready`  out  1  responder can accept; high only in IDLE.
- `acc_type`  in  2  01 = read, 10 = write; 00 and 11 mean no access.
- `access_sz`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `s_us`  in  1  load extension: 0 = signed, 1 = unsigned.
- `dm_adr`  in  32  byte address.
- `sd_32`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle strobe; the access is complete.
- `ld_32`  out  32  extended load data, valid while `rsp_valid` is high.
- `rsp_err`  out  1  misaligned or reserved-size access; valid while `rsp_valid` is high.
- `stall`  out  1  tells the pipeline to hold the MEM stage.

## Operation
- **States:** IDLE, WAIT, RESP.
- **Acceptance:** a request is accepted on an edge where `req_valid`, `req_ready`, and `acc_type` ∈ {01, 10} are all true.
  - On acceptance, `dm_adr`, `access_sz`, `s_us`, `sd_32` and `acc_type` are latched.
  - The latency counter is loaded with `LATENCY-1`.
  - The next state is RESP if `LATENCY` = 1, otherwise WAIT.
- **No-access requests:** requests with `acc_type` 00 or 11 are ignored. There is no state change and no response.
- **WAIT:** the counter decrements each cycle. The state moves to RESP on the edge where the counter is 1.
- **RESP:** `rsp_valid` is 1. The state returns to IDLE on the next edge.
- **Read:** the array word at `adr[ADDR_W-1:2]` is sampled on entry to RESP.
  - Byte lane is selected by `adr[1:0]`; half-word lane by `adr[1]`.
  - The result is sign- or zero-extended per `s_us`. Word reads pass through unchanged.
- **Write:** committed on the edge that ends the RESP cycle, using byte enables.
  - Byte: 0001 shifted left by `adr[1:0]`.
  - Half: 0011 shifted left by `2*adr[1]`.
  - Word: 1111.
  - `sd_32` is replicated into the selected lanes.
  - `ld_32` = 0 for writes.
- **Address range:** addresses at or beyond `DEPTH_WORDS*4` wrap modulo the array size.
- **Stall:** `stall` = (IDLE & `req_valid` & access) | WAIT. It is combinational and low during the RESP cycle, so the MEM stage advances on the edge that ends RESP.

## Timing
- **Reset values:** state = IDLE, `rsp_valid` = 0, `ld_32` = 0, `rsp_err` = 0, counter = 0. While `reset` is high, `req_ready` = 0 and `stall` = 0.
  - Array contents are not reset.
- **Latency:** acceptance at edge N gives `rsp_valid` high in the cycle after edge N+LATENCY-1, i.e. `LATENCY` cycles after acceptance.
- **Throughput:** at most one access per `LATENCY+1` cycles.
- **Reset mid-operation:** the pending access is abandoned and a pending write is dropped. The array is unchanged.
- **Request changes:** changes on the request inputs after acceptance have no effect on the latched access.
- **Read during RESP write:** the array is not read in RESP, so there is no read/write hazard.

## Configuration
- **With `DMEM_MISALIGN_CHECK_EN` defined:** `rsp_err` = 1 and the array is untouched when either:
  - half access with `adr[0]` ≠ 0;
  - word access with `adr[1:0]` ≠ 0, or `access_sz` = 11.
  - In both cases `ld_32` = 0, and timing is unchanged.
- **Without the macro:** `rsp_err` is tied to 0.
  - Half addresses are aligned down on bit 0; word addresses are aligned down on bits 1:0.
  - `access_sz` 11 is treated as word.

## Structure
- **Package `dmem_pkg`:**
  - constants `ACC_READ` = 2'b01, `ACC_WRITE` = 2'b10;
  - `SZ_BYTE`/`SZ_HALF`/`SZ_WORD` encodings;
  - the state enum `dmem_state_t`.
- **Sub-module `dmem_lane_ctrl`:** purely combinational. It generates byte enables, store replication, load lane select and extension, and the misalignment flag. It is instantiated once.
- **Top level:** the FSM, counter, request latches and array live in `dmem_responder`.

## Test plan
- **Word write then read:** `LATENCY`=2; word write 0xDEADBEEF at adr 0x010, then word read of 0x010 → `rsp_valid` 2 cycles after each acceptance, `ld_32` = 0xDEADBEEF, `stall` high for exactly 2 cycles per access.
- **Byte loads:** word 0x80FF7F01 at 0x020; byte reads of 0x021 signed → 0x0000007F, 0x023 signed → 0xFFFFFF80, 0x022 unsigned → 0x000000FF.
- **Half store then read:** half store 0xABCD at 0x032 over word 0x11223344 at 0x030 → word read of 0x030 returns 0xABCD3344; a signed half read of 0x032 returns 0xFFFFABCD.
- **Reset mid-write:** `reset` asserted during WAIT of a write to 0x040 (old value 0x55) → no `rsp_valid`, word 0x040 still reads 0x55, `req_ready` = 1 the cycle after `reset` deasserts.
- **Misaligned word:** word read of 0x041.
  - With `DMEM_MISALIGN_CHECK_EN`: `rsp_err` = 1, `ld_32` = 0.
  - Without it: returns word 0x040, `rsp_err` = 0.
- **No-access request and `LATENCY`=1:** `acc_type` = 00 with `req_valid` = 1 → no response, `stall` = 0, state stays IDLE. With `LATENCY`=1, a read gives `rsp_valid` the cycle after acceptance.
